instruction_decode_param: RTL

//  Parametrised ID stage for the 5-stage MIPS pipeline: register file with write-through bypass,

---
 rtl/mips_pkg.sv | 76 +++++++
 rtl/regfile_bypass.sv | 49 ++++
 rtl/instruction_decode_param.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS ID stage.
//   - opcode / funct constants
//   - HALT_INSTR marker
//   - aluOp / aluSrc / width encodings
//   - halt FSM state enum
//   - control bundle carried into ID/EX
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWU    = 6'h27;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes that need special handling
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // aluOp: EX refines R-type via funct and immediate ops via opcode
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_IMM    = 2'b11;

    // aluSrc: second ALU operand
    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_SHAMT = 2'b10;

    // Memory access width
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic       sign_flag;
        logic [1:0] alu_src;
        logic [1:0] alu_op;
        logic [1:0] width;
    } ctrl_t;

    // Load/store opcodes encode the access size in their two LSBs, matching WIDTH_*.
    function automatic logic [1:0] mem_width(input logic [5:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2-read / 1-write register file, r0 hard-wired to zero.
//   clk, i_rst          clock, synchronous active-high reset (clears all registers)
//   i_we, i_wr_addr,
//   i_wr_data           write port, applied on the clock edge
//   i_rd_addr_a/b       read indices
//   o_rd_data_a/b       read data; a same-cycle write to the read index is returned directly
module regfile_bypass #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr_a,
    input  logic [NB_ADDR-1:0] i_rd_addr_b,
    output logic [NB_DATA-1:0] o_rd_data_a,
    output logic [NB_DATA-1:0] o_rd_data_b
);

    localparam int unsigned NREGS = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] regs [NREGS];
    logic               wr_live;

    assign wr_live = i_we && (i_wr_addr != '0);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Write-through: lets WB and ID share a cycle without a separate forwarding path.
    always_comb begin
        o_rd_data_a = regs[i_rd_addr_a];
        o_rd_data_b = regs[i_rd_addr_b];
        if (wr_live && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
        if (wr_live && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
        if (i_rd_addr_a == '0) o_rd_data_a = '0;
        if (i_rd_addr_b == '0) o_rd_data_b = '0;
    end

endmodule

// File: rtl/instruction_decode_param.sv
// instruction_decode_param: ID stage of the 5-stage MIPS pipeline.
//   Inputs : clk, i_rst (sync, active-high), i_instruction/i_pcounter4/i_valid from IF/ID,
//            i_stall/i_flush from the hazard unit, i_halt debug freeze,
//            WB write port (i_we_wb, i_wr_addr, i_wr_data_WB),
//            EX/MEM forward for branch compare (i_fwd_mem_en/_addr/_data).
//   Outputs: ID/EX register (o_valid, indices, operands, immediate, fields, control),
//            o_jump/o_addr2jump combinational fetch redirect, o_stop sticky drained flag.
module instruction_decode_param
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_ADDR      = 5,
    parameter int unsigned LINK_REG     = 31,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [31:0]        i_instruction,
    input  logic [NB_DATA-1:0] i_pcounter4,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_halt,
    input  logic               i_we_wb,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data_WB,
    input  logic               i_fwd_mem_en,
    input  logic [NB_ADDR-1:0] i_fwd_mem_addr,
    input  logic [NB_DATA-1:0] i_fwd_mem_data,
    output logic               o_valid,
    output logic [NB_ADDR-1:0] o_rs,
    output logic [NB_ADDR-1:0] o_rt,
    output logic [NB_ADDR-1:0] o_rd,
    output logic [NB_DATA-1:0] o_reg_DA,
    output logic [NB_DATA-1:0] o_reg_DB,
    output logic [NB_DATA-1:0] o_immediate,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_func,
    output logic               o_regWrite,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_mem2Reg,
    output logic               o_sign_flag,
    output logic [1:0]         o_aluSrc,
    output logic [1:0]         o_aluOp,
    output logic [1:0]         o_width,
    output logic               o_jump,
    output logic [NB_DATA-1:0] o_addr2jump,
    output logic               o_stop
);

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] rd;
        logic [NB_DATA-1:0] da;
        logic [NB_DATA-1:0] db;
        logic [NB_DATA-1:0] imm;
        logic [5:0]         opcode;
        logic [4:0]         shamt;
        logic [5:0]         func;
        ctrl_t              ctrl;
    } idex_t;

    // Instruction fields
    logic [5:0]         opcode, func;
    logic [4:0]         shamt;
    logic [15:0]        imm16;
    logic [NB_ADDR-1:0] rs_idx, rt_idx, rd_idx;

    assign opcode = i_instruction[31:26];
    assign rs_idx = NB_ADDR'(i_instruction[25:21]);
    assign rt_idx = NB_ADDR'(i_instruction[20:16]);
    assign rd_idx = NB_ADDR'(i_instruction[15:11]);
    assign shamt  = i_instruction[10:6];
    assign func   = i_instruction[5:0];
    assign imm16  = i_instruction[15:0];

    logic [NB_DATA-1:0] rf_a, rf_b;
    logic               rf_we;

    // A frozen pipe must not commit WB writes either.
    assign rf_we = i_we_wb && !i_halt;

    regfile_bypass #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_regfile (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_we        (rf_we),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data_WB),
        .i_rd_addr_a (rs_idx),
        .i_rd_addr_b (rt_idx),
        .o_rd_data_a (rf_a),
        .o_rd_data_b (rf_b)
    );

    halt_state_e state_q;
    logic [3:0]  drain_cnt_q, drain_cnt_inc;
    logic        is_halt_instr, take_halt, load_bubble;

    // Control decode
    ctrl_t              ctrl;
    logic [NB_ADDR-1:0] dest;
    logic               is_link, zext_imm;

    always_comb begin
        ctrl     = '0;
        dest     = '0;
        is_link  = 1'b0;
        zext_imm = 1'b0;
        case (opcode)
            OP_R_TYPE: begin
                if (func == FN_JALR) begin
                    ctrl.reg_write = 1'b1;
                    dest           = rd_idx;
                    is_link        = 1'b1;
                end else if (func != FN_JR) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_OP_RTYPE;
                    ctrl.alu_src   = (func == FN_SLL || func == FN_SRL || func == FN_SRA)
                                     ? ALU_SRC_SHAMT : ALU_SRC_REG;
                    dest           = rd_idx;
                end
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                dest           = NB_ADDR'(LINK_REG);
                is_link        = 1'b1;
            end
            OP_BEQ, OP_BNE: ctrl.alu_op = ALU_OP_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.alu_op    = ALU_OP_IMM;
                dest           = rt_idx;
                zext_imm       = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.width     = mem_width(opcode);
                ctrl.sign_flag = !opcode[2];  // LBU/LHU/LWU have bit 2 set
                dest           = rt_idx;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.width     = mem_width(opcode);
            end
            default: ;  // J and unknown opcodes carry no control
        endcase
    end

    // Branch/jump resolution
    logic               fwd_a, fwd_b, jump_req, jump_ok;
    logic [NB_DATA-1:0] cmp_a, cmp_b, imm_sext, imm_zext, br_target, j_target, jump_tgt;

    assign fwd_a = i_fwd_mem_en && (i_fwd_mem_addr == rs_idx) && (i_fwd_mem_addr != '0);
    assign fwd_b = i_fwd_mem_en && (i_fwd_mem_addr == rt_idx) && (i_fwd_mem_addr != '0);
    assign cmp_a = fwd_a ? i_fwd_mem_data : rf_a;
    assign cmp_b = fwd_b ? i_fwd_mem_data : rf_b;

    assign imm_sext  = {{(NB_DATA-16){imm16[15]}}, imm16};
    assign imm_zext  = {{(NB_DATA-16){1'b0}}, imm16};
    assign br_target = i_pcounter4 + (imm_sext << 2);

    always_comb begin
        j_target       = i_pcounter4;
        j_target[27:0] = {i_instruction[25:0], 2'b00};
    end

    always_comb begin
        jump_req = 1'b0;
        jump_tgt = br_target;
        case (opcode)
            OP_BEQ: jump_req = (cmp_a == cmp_b);
            OP_BNE: jump_req = (cmp_a != cmp_b);
            OP_J, OP_JAL: begin
                jump_req = 1'b1;
                jump_tgt = j_target;
            end
            OP_R_TYPE: begin
                jump_req = (func == FN_JR) || (func == FN_JALR);
                jump_tgt = cmp_a;
            end
            default: ;
        endcase
    end

    assign jump_ok     = i_valid && !i_stall && !i_flush && !i_halt && (state_q == RUN);
    assign o_jump      = jump_ok && jump_req;
    assign o_addr2jump = jump_tgt;

    // Halt FSM
    assign is_halt_instr = (i_instruction == HALT_INSTR);
    assign take_halt     = i_valid && is_halt_instr && !i_stall && !i_flush;
    assign drain_cnt_inc = drain_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            o_stop      <= 1'b0;
        end else if (!i_halt) begin
            case (state_q)
                RUN: begin
                    if (take_halt) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_inc;
                    if (drain_cnt_inc == 4'(DRAIN_CYCLES)) begin
                        state_q <= HALTED;
                        o_stop  <= 1'b1;
                    end
                end
                HALTED:  o_stop <= 1'b1;
                default: state_q <= RUN;
            endcase
        end
    end

    // ID/EX register
    idex_t idex_d, idex_q;

    assign load_bubble = !i_valid || i_stall || i_flush || (state_q != RUN) || is_halt_instr;

    always_comb begin
        idex_d = '0;
        if (!load_bubble) begin
            idex_d.valid  = 1'b1;
            idex_d.rs     = rs_idx;
            idex_d.rt     = rt_idx;
            idex_d.rd     = dest;
            idex_d.da     = is_link ? i_pcounter4 : rf_a;
            idex_d.db     = is_link ? NB_DATA'(4) : rf_b;
            idex_d.imm    = zext_imm ? imm_zext : imm_sext;
            idex_d.opcode = opcode;
            idex_d.shamt  = shamt;
            idex_d.func   = func;
            idex_d.ctrl   = ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            idex_q <= '0;
        end else if (!i_halt) begin
            idex_q <= idex_d;
        end
    end

    assign o_valid     = idex_q.valid;
    assign o_rs        = idex_q.rs;
    assign o_rt        = idex_q.rt;
    assign o_rd        = idex_q.rd;
    assign o_reg_DA    = idex_q.da;
    assign o_reg_DB    = idex_q.db;
    assign o_immediate = idex_q.imm;
    assign o_opcode    = idex_q.opcode;
    assign o_shamt     = idex_q.shamt;
    assign o_func      = idex_q.func;
    assign o_regWrite  = idex_q.ctrl.reg_write;
    assign o_memRead   = idex_q.ctrl.mem_read;
    assign o_memWrite  = idex_q.ctrl.mem_write;
    assign o_mem2Reg   = idex_q.ctrl.mem2reg;
    assign o_sign_flag = idex_q.ctrl.sign_flag;
    assign o_aluSrc    = idex_q.ctrl.alu_src;
    assign o_aluOp     = idex_q.ctrl.alu_op;
    assign o_width     = idex_q.ctrl.width;

endmodule
